// File: rtl/multi_range_finder.sv
`default_nettype none
// ============================================================================
// Module   : multi_range_finder
// Brief    : Multi-channel framed min/max/range/count tracker. Each channel
//            runs independent go..finish sessions; define RANGE_SIGNED_EN
//            for two's-complement samples and signed comparisons.
// Revision : 1.0 - initial release
// ============================================================================
module multi_range_finder #(
    parameter int WIDTH     = 16,
    parameter int CHANNELS  = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic [$clog2(CHANNELS)-1:0] in_ch,
    input  logic [WIDTH-1:0]            data_in,
    input  logic                        go,
    input  logic                        finish,
    output logic [CHANNELS-1:0]         ch_active,
    output logic                        res_valid,
    output logic [$clog2(CHANNELS)-1:0] res_ch,
    output logic [WIDTH-1:0]            res_min,
    output logic [WIDTH-1:0]            res_max,
    output logic [WIDTH:0]              res_range,
    output logic [CNT_WIDTH-1:0]        res_count,
    output logic                        err_valid,
    output logic [$clog2(CHANNELS)-1:0] err_ch
);

    localparam int CH_W = $clog2(CHANNELS);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    logic [CHANNELS-1:0] done_vec;
    logic [CHANNELS-1:0] err_vec;
    logic [WIDTH-1:0]     nxt_min [CHANNELS];
    logic [WIDTH-1:0]     nxt_max [CHANNELS];
    logic [CNT_WIDTH-1:0] nxt_cnt [CHANNELS];

    logic [WIDTH-1:0]     sel_min;
    logic [WIDTH-1:0]     sel_max;
    logic [CNT_WIDTH-1:0] sel_cnt;
    logic [WIDTH:0]       sel_range;

    function automatic logic smaller(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef RANGE_SIGNED_EN
        return $signed(a) < $signed(b);
`else
        return a < b;
`endif
    endfunction

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
            state_t               state;
            logic [WIDTH-1:0]     min_q;
            logic [WIDTH-1:0]     max_q;
            logic [CNT_WIDTH-1:0] cnt_q;
            logic                 sel;
            logic                 is_err;
            logic                 is_start;
            logic                 is_upd;

            // Out-of-range tags never match any channel index, so they fall through silently.
            assign sel      = in_valid && (in_ch == CH_W'(i));
            assign is_err   = sel && ((go && finish) ||
                                      (state == IDLE && finish) ||
                                      (state == RECV && go));
            assign is_start = sel && (state == IDLE) && go && !finish;
            assign is_upd   = sel && (state == RECV) && !go;

            assign nxt_min[i] = smaller(data_in, min_q) ? data_in : min_q;
            assign nxt_max[i] = smaller(max_q, data_in) ? data_in : max_q;
            assign nxt_cnt[i] = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);

            assign done_vec[i]  = is_upd && finish;
            assign err_vec[i]   = is_err;
            assign ch_active[i] = (state == RECV);

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    state <= IDLE;
                    min_q <= '0;
                    max_q <= '0;
                    cnt_q <= '0;
                end else if (is_err) begin
                    state <= IDLE;
                end else if (is_start) begin
                    state <= RECV;
                    min_q <= data_in;
                    max_q <= data_in;
                    cnt_q <= CNT_WIDTH'(1);
                end else if (is_upd) begin
                    min_q <= nxt_min[i];
                    max_q <= nxt_max[i];
                    cnt_q <= nxt_cnt[i];
                    if (finish) begin
                        state <= IDLE;
                    end
                end
            end
        end
    endgenerate

    // At most one channel completes per cycle, so an OR-style mux is sufficient.
    always_comb begin
        sel_min = '0;
        sel_max = '0;
        sel_cnt = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (done_vec[i]) begin
                sel_min = nxt_min[i];
                sel_max = nxt_max[i];
                sel_cnt = nxt_cnt[i];
            end
        end
    end

`ifdef RANGE_SIGNED_EN
    assign sel_range = {sel_max[WIDTH-1], sel_max} - {sel_min[WIDTH-1], sel_min};
`else
    assign sel_range = {1'b0, sel_max} - {1'b0, sel_min};
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            res_valid <= 1'b0;
            res_ch    <= '0;
            res_min   <= '0;
            res_max   <= '0;
            res_range <= '0;
            res_count <= '0;
            err_valid <= 1'b0;
            err_ch    <= '0;
        end else begin
            res_valid <= |done_vec;
            err_valid <= |err_vec;
            if (|done_vec) begin
                res_ch    <= in_ch;
                res_min   <= sel_min;
                res_max   <= sel_max;
                res_range <= sel_range;
                res_count <= sel_cnt;
            end
            if (|err_vec) begin
                err_ch <= in_ch;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_range_finder.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_range_finder
// Brief    : Directed self-checking bench for multi_range_finder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_range_finder;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic [1:0]  in_ch;
    logic [15:0] data_in;
    logic        go;
    logic        finish;
    logic [3:0]  ch_active;
    logic        res_valid;
    logic [1:0]  res_ch;
    logic [15:0] res_min;
    logic [15:0] res_max;
    logic [16:0] res_range;
    logic [7:0]  res_count;
    logic        err_valid;
    logic [1:0]  err_ch;

    logic        s_in_valid;
    logic [0:0]  s_in_ch;
    logic [7:0]  s_data;
    logic        s_go;
    logic        s_finish;
    logic [1:0]  s_ch_active;
    logic        s_res_valid;
    logic [0:0]  s_res_ch;
    logic [7:0]  s_res_min;
    logic [7:0]  s_res_max;
    logic [8:0]  s_res_range;
    logic [3:0]  s_res_count;
    logic        s_err_valid;
    logic [0:0]  s_err_ch;

    int n_pass;
    int n_total;

    multi_range_finder #(.WIDTH(16), .CHANNELS(4), .CNT_WIDTH(8)) u_dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ch(in_ch),
        .data_in(data_in), .go(go), .finish(finish), .ch_active(ch_active),
        .res_valid(res_valid), .res_ch(res_ch), .res_min(res_min), .res_max(res_max),
        .res_range(res_range), .res_count(res_count), .err_valid(err_valid), .err_ch(err_ch)
    );

    multi_range_finder #(.WIDTH(8), .CHANNELS(2), .CNT_WIDTH(4)) u_small (
        .clock(clock), .reset(reset), .in_valid(s_in_valid), .in_ch(s_in_ch),
        .data_in(s_data), .go(s_go), .finish(s_finish), .ch_active(s_ch_active),
        .res_valid(s_res_valid), .res_ch(s_res_ch), .res_min(s_res_min), .res_max(s_res_max),
        .res_range(s_res_range), .res_count(s_res_count), .err_valid(s_err_valid), .err_ch(s_err_ch)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Drive one beat; on return the registered outputs reflect that beat.
    task automatic beat(input logic v, input logic [1:0] ch, input logic [15:0] d,
                        input logic g, input logic f);
        in_valid = v; in_ch = ch; data_in = d; go = g; finish = f;
        @(posedge clock); #1;
        in_valid = 1'b0; go = 1'b0; finish = 1'b0;
    endtask

    task automatic s_beat(input logic [0:0] ch, input logic [7:0] d, input logic g, input logic f);
        s_in_valid = 1'b1; s_in_ch = ch; s_data = d; s_go = g; s_finish = f;
        @(posedge clock); #1;
        s_in_valid = 1'b0; s_go = 1'b0; s_finish = 1'b0;
    endtask

    task automatic test_reset();
        n_total++; if (ch_active !== 4'b0000) $display("FAIL reset_active got %b exp 0000", ch_active); else n_pass++;
        n_total++; if (res_valid !== 1'b0) $display("FAIL reset_res_valid got %b exp 0", res_valid); else n_pass++;
        n_total++; if (err_valid !== 1'b0) $display("FAIL reset_err_valid got %b exp 0", err_valid); else n_pass++;
        n_total++; if ({res_min, res_max, res_range, res_count, res_ch, err_ch} !== '0)
            $display("FAIL reset_regs got min=%0d max=%0d range=%0d cnt=%0d exp all 0", res_min, res_max, res_range, res_count); else n_pass++;
    endtask

    task automatic test_basic();
        beat(1, 0, 16'd100, 1, 0);
        n_total++; if (ch_active !== 4'b0001) $display("FAIL basic_active got %b exp 0001", ch_active); else n_pass++;
        beat(1, 0, 16'd40, 0, 0);
        beat(1, 0, 16'd250, 0, 0);
        n_total++; if (res_valid !== 1'b0) $display("FAIL basic_early_valid got %b exp 0", res_valid); else n_pass++;
        beat(1, 0, 16'd7, 0, 1);
        n_total++; if (res_valid !== 1'b1 || res_ch !== 2'd0) $display("FAIL basic_valid got v=%b ch=%0d exp v=1 ch=0", res_valid, res_ch); else n_pass++;
        n_total++; if (res_min !== 16'd7 || res_max !== 16'd250) $display("FAIL basic_minmax got %0d/%0d exp 7/250", res_min, res_max); else n_pass++;
        n_total++; if (res_range !== 17'd243 || res_count !== 8'd4) $display("FAIL basic_range_cnt got %0d/%0d exp 243/4", res_range, res_count); else n_pass++;
        n_total++; if (ch_active !== 4'b0000) $display("FAIL basic_idle got %b exp 0000", ch_active); else n_pass++;
        beat(0, 0, 16'd0, 0, 0);
        n_total++; if (res_valid !== 1'b0 || res_min !== 16'd7 || res_count !== 8'd4)
            $display("FAIL basic_hold got v=%b min=%0d cnt=%0d exp v=0 min=7 cnt=4", res_valid, res_min, res_count); else n_pass++;
    endtask

    task automatic test_interleave();
        beat(1, 1, 16'd5, 1, 0);
        beat(1, 2, 16'd1000, 1, 0);
        n_total++; if (ch_active !== 4'b0110) $display("FAIL il_active got %b exp 0110", ch_active); else n_pass++;
        beat(1, 1, 16'd9, 0, 1);
        n_total++; if (res_valid !== 1'b1 || res_ch !== 2'd1 || res_min !== 16'd5 || res_max !== 16'd9 ||
                       res_range !== 17'd4 || res_count !== 8'd2)
            $display("FAIL il_ch1 got v=%b ch=%0d %0d/%0d/%0d/%0d exp 1 1 5/9/4/2", res_valid, res_ch, res_min, res_max, res_range, res_count); else n_pass++;
        n_total++; if (ch_active !== 4'b0100) $display("FAIL il_active2 got %b exp 0100", ch_active); else n_pass++;
        beat(1, 2, 16'd3, 0, 0);
        n_total++; if (res_valid !== 1'b0) $display("FAIL il_mid_valid got %b exp 0", res_valid); else n_pass++;
        beat(1, 2, 16'd500, 0, 1);
        n_total++; if (res_valid !== 1'b1 || res_ch !== 2'd2 || res_min !== 16'd3 || res_max !== 16'd1000 ||
                       res_range !== 17'd997 || res_count !== 8'd3)
            $display("FAIL il_ch2 got v=%b ch=%0d %0d/%0d/%0d/%0d exp 1 2 3/1000/997/3", res_valid, res_ch, res_min, res_max, res_range, res_count); else n_pass++;
    endtask

    task automatic test_errors();
        beat(1, 3, 16'd1, 0, 1);
        n_total++; if (err_valid !== 1'b1 || err_ch !== 2'd3 || res_valid !== 1'b0)
            $display("FAIL err_idle_finish got e=%b ch=%0d r=%b exp 1 3 0", err_valid, err_ch, res_valid); else n_pass++;
        beat(1, 0, 16'd1, 1, 1);
        n_total++; if (err_valid !== 1'b1 || err_ch !== 2'd0 || ch_active !== 4'b0000)
            $display("FAIL err_gofin got e=%b ch=%0d act=%b exp 1 0 0000", err_valid, err_ch, ch_active); else n_pass++;
        beat(1, 1, 16'd10, 1, 0);
        n_total++; if (err_valid !== 1'b0) $display("FAIL err_pulse got %b exp 0", err_valid); else n_pass++;
        beat(1, 1, 16'd20, 0, 0);
        beat(1, 1, 16'd30, 1, 0);
        n_total++; if (err_valid !== 1'b1 || err_ch !== 2'd1 || ch_active !== 4'b0000)
            $display("FAIL err_go_recv got e=%b ch=%0d act=%b exp 1 1 0000", err_valid, err_ch, ch_active); else n_pass++;
        beat(0, 0, 16'd0, 0, 0);
        beat(0, 0, 16'd0, 0, 0);
        n_total++; if (res_valid !== 1'b0 || err_valid !== 1'b0)
            $display("FAIL err_quiet got r=%b e=%b exp 0 0", res_valid, err_valid); else n_pass++;
    endtask

    task automatic test_back_to_back();
        beat(1, 0, 16'd10, 1, 0);
        beat(1, 0, 16'd20, 0, 1);
        beat(1, 0, 16'd30, 1, 0);
        n_total++; if (err_valid !== 1'b0 || ch_active !== 4'b0001 || res_valid !== 1'b0)
            $display("FAIL b2b_restart got e=%b act=%b r=%b exp 0 0001 0", err_valid, ch_active, res_valid); else n_pass++;
        beat(1, 0, 16'd5, 0, 1);
        n_total++; if (res_valid !== 1'b1 || res_min !== 16'd5 || res_max !== 16'd30 ||
                       res_range !== 17'd25 || res_count !== 8'd2)
            $display("FAIL b2b_result got v=%b %0d/%0d/%0d/%0d exp 1 5/30/25/2", res_valid, res_min, res_max, res_range, res_count); else n_pass++;
    endtask

    task automatic test_invalid();
        beat(0, 0, 16'd77, 1, 0);
        n_total++; if (ch_active !== 4'b0000 || err_valid !== 1'b0)
            $display("FAIL inv_go got act=%b e=%b exp 0000 0", ch_active, err_valid); else n_pass++;
        beat(0, 3, 16'd77, 1, 1);
        n_total++; if (err_valid !== 1'b0 || res_valid !== 1'b0)
            $display("FAIL inv_gofin got e=%b r=%b exp 0 0", err_valid, res_valid); else n_pass++;
    endtask

    task automatic test_reset_mid();
        beat(1, 2, 16'd50, 1, 0);
        n_total++; if (ch_active !== 4'b0100) $display("FAIL rm_active got %b exp 0100", ch_active); else n_pass++;
        reset = 1'b1;
        #2;
        n_total++; if (ch_active !== 4'b0000 || res_min !== 16'd0)
            $display("FAIL rm_async got act=%b min=%0d exp 0000 0", ch_active, res_min); else n_pass++;
        reset = 1'b0;
        @(posedge clock); #1;
        beat(1, 2, 16'd60, 0, 1);
        n_total++; if (err_valid !== 1'b1 || err_ch !== 2'd2 || res_valid !== 1'b0)
            $display("FAIL rm_finish got e=%b ch=%0d r=%b exp 1 2 0", err_valid, err_ch, res_valid); else n_pass++;
    endtask

    task automatic test_saturate();
        s_beat(1, 8'd50, 1, 0);
        for (int k = 1; k <= 18; k++) s_beat(1, 8'(50 + k), 0, 0);
        s_beat(1, 8'd10, 0, 1);
        n_total++; if (s_res_valid !== 1'b1 || s_res_ch !== 1'b1 || s_res_count !== 4'd15)
            $display("FAIL sat_count got v=%b ch=%0d cnt=%0d exp 1 1 15", s_res_valid, s_res_ch, s_res_count); else n_pass++;
        n_total++; if (s_res_min !== 8'd10 || s_res_max !== 8'd68 || s_res_range !== 9'd58)
            $display("FAIL sat_minmax got %0d/%0d/%0d exp 10/68/58", s_res_min, s_res_max, s_res_range); else n_pass++;
    endtask

    task automatic test_span();
        s_beat(0, 8'h80, 1, 0);
        s_beat(0, 8'h7F, 0, 1);
`ifdef RANGE_SIGNED_EN
        n_total++; if (s_res_min !== 8'h80 || s_res_max !== 8'h7F || s_res_range !== 9'd255)
            $display("FAIL span got %h/%h/%0d exp 80/7f/255", s_res_min, s_res_max, s_res_range); else n_pass++;
`else
        n_total++; if (s_res_min !== 8'h7F || s_res_max !== 8'h80 || s_res_range !== 9'd1)
            $display("FAIL span got %h/%h/%0d exp 7f/80/1", s_res_min, s_res_max, s_res_range); else n_pass++;
`endif
        n_total++; if (s_res_count !== 4'd2 || s_res_ch !== 1'b0)
            $display("FAIL span_cnt got cnt=%0d ch=%0d exp 2 0", s_res_count, s_res_ch); else n_pass++;
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        reset = 1'b1;
        in_valid = 1'b0; in_ch = '0; data_in = '0; go = 1'b0; finish = 1'b0;
        s_in_valid = 1'b0; s_in_ch = '0; s_data = '0; s_go = 1'b0; s_finish = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        test_reset();
        test_basic();
        test_interleave();
        test_errors();
        test_back_to_back();
        test_invalid();
        test_reset_mid();
        test_saturate();
        test_span();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multi_range_finder.md
# multi_range_finder

Multi-channel, framed min/max/range tracker. Samples arrive one per cycle, tagged with a channel number; each channel runs independent go…finish sessions. On each completed session the block reports min, max, range and sample count for that channel. It is the parametrised successor to the single-channel range finder and sits directly downstream of the sample mux in the measurement datapath.

## Interface
- WIDTH, 16, sample width in bits (>= 2)
- CHANNELS, 4, number of independent channels (>= 2)
- CNT_WIDTH, 8, session sample-count width; count saturates
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  qualifies in_ch, data_in, go, finish; all ignored when low
- in_ch  input  $clog2(CHANNELS)  channel tag of the current beat
- data_in  input  WIDTH  sample
- go  input  1  beat is first sample of a session on in_ch
- finish  input  1  beat is last sample of a session on in_ch
- ch_active  output  CHANNELS  bit i high while channel i is in RECV
- res_valid  output  1  one-cycle pulse: session completed
- res_ch  output  $clog2(CHANNELS)  channel of the completed session
- res_min, res_max  output  WIDTH  extremes of the session, including first and last samples
- res_range  output  WIDTH+1  res_max - res_min
- res_count  output  CNT_WIDTH  samples in session, saturating at 2^CNT_WIDTH-1
- err_valid  output  1  one-cycle pulse: protocol error
- err_ch  output  $clog2(CHANNELS)  channel on which the error occurred

## Operation
- Per-channel state machine, IDLE/RECV, plus per-channel min, max and count registers.
- Only beats with in_valid=1 are accepted. Only channel in_ch is affected.
- IDLE, go=1, finish=0: load min=max=data_in, count=1, enter RECV.
- IDLE, go=0, finish=0: beat ignored, no error.
- RECV, go=0: update min/max with data_in and increment count (saturating).
- RECV, go=0, finish=1: the sample is included, the result is issued and the channel returns to IDLE.
- Error cases:
  - go=1 and finish=1 in any state.
  - finish=1 in IDLE.
  - go=1 in RECV.
- On any error:
  - err_valid pulses with err_ch=in_ch.
  - The channel goes to IDLE and its partial session is discarded; no result is issued.
  - The erroring beat does not start a new session.
- Comparisons are unsigned. res_range MSB is always 0 in unsigned mode.
- in_ch >= CHANNELS: beat ignored, no error.
- Reset values: all channels IDLE, all registers 0. Outputs: ch_active=0, res_valid=0, err_valid=0, all res_*/err_ch=0.
- Reset mid-session aborts all sessions silently.

## Timing
- Fully registered outputs.
- res_* and res_valid appear the cycle after the finish beat; res_valid stays high for exactly one cycle.
- err_valid appears the cycle after the erroring beat.
- res_min/max/range/count/ch hold their last value until the next res_valid.
- ch_active updates the cycle after the accepted go or finish beat, or the erroring beat.
- Result and error cannot coincide: there is one beat per cycle.
- Back-to-back sessions:
  - A new go on a channel is legal the cycle after its finish beat.
  - Interleaved beats across channels are legal every cycle.
- Single-sample sessions do not exist: go and finish together is an error.

## Configuration
- RANGE_SIGNED_EN:
  - Defined: data_in is two's complement and min/max comparisons are signed. res_range = res_max - res_min computed in WIDTH+1 bits, always non-negative; the full span up to 2^WIDTH-1 is representable.
  - Undefined: unsigned comparisons, as described above.

## Test plan
- WIDTH=16, ch0: go with 100, then 40, 250, then finish with 7 → the cycle after finish: res_valid=1, res_ch=0, min=7, max=250, range=243, count=4.
- Interleave ch1 (go 5, finish 9) and ch2 (go 1000, 3, finish 500) beat by beat:
  - ch1 result: min 5, max 9, range 4, count 2.
  - ch2 result: min 3, max 1000, range 997, count 3.
  - ch_active bits track each channel.
- Error cases:
  - finish on idle ch3 → err_valid=1, err_ch=3.
  - go+finish on ch0 → err_valid=1, err_ch=0.
  - go on ch1 mid-session → err_valid=1, err_ch=1; ch1 returns to IDLE and no res_valid follows.
- in_valid=0 beats carrying go/finish are ignored entirely. Assert reset mid-session → ch_active=0; a later finish on that channel → error.
- CNT_WIDTH=4, 20-sample session → res_count=15.
- RANGE_SIGNED_EN, WIDTH=8: go with -128, finish with 127 → min=-128, max=127, res_range=255.
